// File: rtl/move_piece_pkg.sv
// -----------------------------------------------------------------------------
// move_piece_pkg
//
// Purpose: definitions shared by the piece mover and the game-control FSM.
//   - move_state_e : state encoding of move_piece_fsm
//   - game_phase_e : top-level game phases (GEN/MOVE/LAND/CLEAR/NEWBOARD);
//                    move_piece_fsm is driven while the game is in MOVE
//   - PIECE_SQUARE : piece type that is rotation-invariant
//   - rot_next()   : quarter-turn increment, 3 wraps to 0
// -----------------------------------------------------------------------------
package move_piece_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        SHIFT = 3'd2,
        FALL  = 3'd3,
        DONE  = 3'd4
    } move_state_e;

    typedef enum logic [2:0] {
        GEN      = 3'd0,
        MOVE     = 3'd1,
        LAND     = 3'd2,
        CLEAR    = 3'd3,
        NEWBOARD = 3'd4
    } game_phase_e;

    localparam logic [1:0] PIECE_SQUARE = 2'b00;

    // Two-bit add wraps naturally: 3 -> 0.
    function automatic logic [1:0] rot_next(input logic [1:0] rot);
        return rot + 2'd1;
    endfunction

endpackage

// File: rtl/piece_coords.sv
// -----------------------------------------------------------------------------
// piece_coords
//
// Purpose: combinational split of a linear board location into column and row.
//   location = row*BOARD_W + col, row 0 is the top of the board.
//
// Ports:
//   loc_i  [LOC_W-1:0]  linear location
//   col_o  [COL_W-1:0]  loc_i % BOARD_W
//   row_o  [ROW_W-1:0]  loc_i / BOARD_W
// -----------------------------------------------------------------------------
module piece_coords #(
    parameter int BOARD_W = 4,
    parameter int BOARD_H = 8,
    parameter int LOC_W   = $clog2(BOARD_W*BOARD_H),
    parameter int COL_W   = $clog2(BOARD_W),
    parameter int ROW_W   = $clog2(BOARD_H)
) (
    input  logic [LOC_W-1:0] loc_i,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o
);

    // Divisor held at location width so the arithmetic stays in LOC_W bits.
    localparam logic [LOC_W-1:0] WIDTH_L = LOC_W'(BOARD_W);

    logic [LOC_W-1:0] col_full;
    logic [LOC_W-1:0] row_full;

    assign col_full = loc_i % WIDTH_L;
    assign row_full = loc_i / WIDTH_L;

    // Any legal location gives col < BOARD_W and row < BOARD_H, so the
    // narrowing casts drop only zero bits.
    assign col_o = COL_W'(col_full);
    assign row_o = ROW_W'(row_full);

endmodule

// File: rtl/move_piece_fsm.sv
// -----------------------------------------------------------------------------
// move_piece_fsm
//
// Purpose: applies one user move (left > right > rotate priority) to the
// current piece, then one row of gravity, and reports whether the piece has
// reached the bottom row. Used by the game-control FSM during its MOVE phase.
//
// Sequence: IDLE -> LATCH -> SHIFT -> FALL -> DONE -> IDLE
//   start accepted at edge N, done pulses in the cycle after edge N+4.
//
// Optional feature (compile-time macro MOVE_PIECE_HARD_DROP_EN):
//   when defined, a request with drop=1 keeps falling one row per cycle in
//   FALL until the bottom row; latency becomes 3 + max(1, BOARD_H-1-row).
//   When undefined, the drop input is ignored.
//
// Ports:
//   clka                 in   clock, rising edge
//   reset                in   asynchronous, active-high
//   start                in   request pulse, sampled only in IDLE
//   curr_piece_type      in   [1:0], 2'b00 = square
//   curr_piece_location  in   [LOC_W-1:0], row*BOARD_W + col
//   curr_piece_rotation  in   [1:0]
//   left/right/rotate    in   user controls, sampled with start
//   drop                 in   hard-drop request, sampled with start
//   new_location         out  [LOC_W-1:0], registered result
//   new_rotation         out  [1:0], registered result
//   landed               out  piece sits on the bottom row, valid with done
//   busy                 out  request in progress
//   done                 out  one-cycle pulse, results valid
// -----------------------------------------------------------------------------
module move_piece_fsm #(
    parameter int BOARD_W = 4,
    parameter int BOARD_H = 8,
    parameter int LOC_W   = $clog2(BOARD_W*BOARD_H)
) (
    input  logic             clka,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       curr_piece_type,
    input  logic [LOC_W-1:0] curr_piece_location,
    input  logic [1:0]       curr_piece_rotation,
    input  logic             left,
    input  logic             right,
    input  logic             rotate,
    input  logic             drop,
    output logic [LOC_W-1:0] new_location,
    output logic [1:0]       new_rotation,
    output logic             landed,
    output logic             busy,
    output logic             done
);

    import move_piece_pkg::*;

    localparam int COL_W = $clog2(BOARD_W);
    localparam int ROW_W = $clog2(BOARD_H);

    localparam logic [LOC_W-1:0] LOC_ONE  = LOC_W'(1);
    localparam logic [LOC_W-1:0] LOC_STEP = LOC_W'(BOARD_W);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(BOARD_W - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(BOARD_H - 1);
    localparam logic [ROW_W-1:0] ROW_PEN  = ROW_W'(BOARD_H - 2);

    // Control / output state (reset)
    move_state_e      state_q,   state_d;
    logic [LOC_W-1:0] new_loc_q, new_loc_d;
    logic [1:0]       new_rot_q, new_rot_d;
    logic             landed_q,  landed_d;
    logic             done_q,    done_d;

    // Captured request and working values (loaded on accept, no reset needed)
    logic [LOC_W-1:0] loc_q,    loc_d;
    logic [1:0]       rot_q,    rot_d;
    logic [1:0]       typ_q,    typ_d;
    logic             left_q,   left_d;
    logic             right_q,  right_d;
    logic             rotate_q, rotate_d;
    logic [COL_W-1:0] col_q,    col_d;
    logic [ROW_W-1:0] row_q,    row_d;
    logic             land_q,   land_d;

`ifdef MOVE_PIECE_HARD_DROP_EN
    logic             drop_q,   drop_d;
`else
    logic             unused_drop;
    assign unused_drop = drop;
`endif

    logic [COL_W-1:0] coord_col;
    logic [ROW_W-1:0] coord_row;
    logic             row_last;
    logic             row_pen;

    piece_coords #(
        .BOARD_W (BOARD_W),
        .BOARD_H (BOARD_H),
        .LOC_W   (LOC_W),
        .COL_W   (COL_W),
        .ROW_W   (ROW_W)
    ) u_coords (
        .loc_i (loc_q),
        .col_o (coord_col),
        .row_o (coord_row)
    );

    assign row_last = (row_q == ROW_LAST);
    assign row_pen  = (row_q == ROW_PEN);

    // ---------------------------------------------------------------------
    // Next-state and datapath
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        new_loc_d = new_loc_q;
        new_rot_d = new_rot_q;
        landed_d  = landed_q;
        done_d    = 1'b0;
        loc_d     = loc_q;
        rot_d     = rot_q;
        typ_d     = typ_q;
        left_d    = left_q;
        right_d   = right_q;
        rotate_d  = rotate_q;
        col_d     = col_q;
        row_d     = row_q;
        land_d    = land_q;
`ifdef MOVE_PIECE_HARD_DROP_EN
        drop_d    = drop_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    loc_d    = curr_piece_location;
                    rot_d    = curr_piece_rotation;
                    typ_d    = curr_piece_type;
                    left_d   = left;
                    right_d  = right;
                    rotate_d = rotate;
                    land_d   = 1'b0;
`ifdef MOVE_PIECE_HARD_DROP_EN
                    drop_d   = drop;
`endif
                    state_d  = LATCH;
                end
            end

            LATCH: begin
                col_d   = coord_col;
                row_d   = coord_row;
                state_d = SHIFT;
            end

            SHIFT: begin
                // Edge columns hold instead of wrapping into the neighbour row.
                if (left_q) begin
                    if (col_q != '0) begin
                        loc_d = loc_q - LOC_ONE;
                        col_d = col_q - COL_ONE;
                    end
                end else if (right_q) begin
                    if (col_q != COL_LAST) begin
                        loc_d = loc_q + LOC_ONE;
                        col_d = col_q + COL_ONE;
                    end
                end else if (rotate_q) begin
                    if (typ_q != PIECE_SQUARE) begin
                        rot_d = rot_next(rot_q);
                    end
                end
                state_d = FALL;
            end

            FALL: begin
                // On the bottom row the piece stays put; otherwise drop one
                // row and flag landing if that row is the bottom one.
                if (row_last) begin
                    land_d = 1'b1;
                end else begin
                    loc_d  = loc_q + LOC_STEP;
                    row_d  = row_q + ROW_ONE;
                    land_d = row_pen;
                end
                state_d = DONE;
`ifdef MOVE_PIECE_HARD_DROP_EN
                // Hard drop keeps looping while at least two rows remain.
                if (drop_q && !row_last && !row_pen) begin
                    state_d = FALL;
                end
`endif
            end

            DONE: begin
                new_loc_d = loc_q;
                new_rot_d = rot_q;
                landed_d  = land_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Control and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            new_loc_q <= '0;
            new_rot_q <= '0;
            landed_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            new_loc_q <= new_loc_d;
            new_rot_q <= new_rot_d;
            landed_q  <= landed_d;
            done_q    <= done_d;
        end
    end

    // ---------------------------------------------------------------------
    // Request / working registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clka) begin
        loc_q    <= loc_d;
        rot_q    <= rot_d;
        typ_q    <= typ_d;
        left_q   <= left_d;
        right_q  <= right_d;
        rotate_q <= rotate_d;
        col_q    <= col_d;
        row_q    <= row_d;
        land_q   <= land_d;
`ifdef MOVE_PIECE_HARD_DROP_EN
        drop_q   <= drop_d;
`endif
    end

    assign new_location = new_loc_q;
    assign new_rotation = new_rot_q;
    assign landed       = landed_q;
    assign done         = done_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_move_piece_fsm.sv
// -----------------------------------------------------------------------------
// tb_move_piece_fsm
//
// Self-checking bench for move_piece_fsm. Each request pushes its expected
// result (location, rotation, landed, latency) onto a queue; the result is
// popped and compared when done pulses. Board is 4x8 by default, 5x6 when
// MOVE_PIECE_HARD_DROP_EN is defined.
// -----------------------------------------------------------------------------
module tb_move_piece_fsm;

`ifdef MOVE_PIECE_HARD_DROP_EN
    localparam int BW = 5;
    localparam int BH = 6;
    localparam bit HD = 1'b1;
`else
    localparam int BW = 4;
    localparam int BH = 8;
    localparam bit HD = 1'b0;
`endif
    localparam int LW = $clog2(BW*BH);

    logic          clka;
    logic          reset;
    logic          start;
    logic [1:0]    curr_piece_type;
    logic [LW-1:0] curr_piece_location;
    logic [1:0]    curr_piece_rotation;
    logic          left, right, rotate, drop;
    logic [LW-1:0] new_location;
    logic [1:0]    new_rotation;
    logic          landed, busy, done;

    move_piece_fsm #(
        .BOARD_W (BW),
        .BOARD_H (BH)
    ) dut (
        .clka                (clka),
        .reset               (reset),
        .start               (start),
        .curr_piece_type     (curr_piece_type),
        .curr_piece_location (curr_piece_location),
        .curr_piece_rotation (curr_piece_rotation),
        .left                (left),
        .right               (right),
        .rotate              (rotate),
        .drop                (drop),
        .new_location        (new_location),
        .new_rotation        (new_rotation),
        .landed              (landed),
        .busy                (busy),
        .done                (done)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    typedef struct {
        logic [LW-1:0] loc;
        logic [1:0]    rot;
        logic          landed;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Reference behaviour in board coordinates.
    function automatic exp_t model(input int loc, input int rot, input int typ,
                                   input bit l, input bit r, input bit ro, input bit dr);
        exp_t e;
        int col, row, rows_left;
        col = loc % BW;
        row = loc / BW;
        e.rot = 2'(rot);
        if (l) begin
            if (col > 0) col = col - 1;
        end else if (r) begin
            if (col < BW - 1) col = col + 1;
        end else if (ro) begin
            if (typ != 0) e.rot = 2'((rot + 1) % 4);
        end
        if (HD && dr) begin
            rows_left = BH - 1 - row;
            e.lat    = 3 + ((rows_left > 1) ? rows_left : 1);
            row      = BH - 1;
            e.landed = 1'b1;
        end else begin
            e.lat = 4;
            if (row < BH - 1) row = row + 1;
            e.landed = (row == BH - 1);
        end
        e.loc = LW'(row * BW + col);
        return e;
    endfunction

    // Drive one request, accepted at the next rising edge; afterwards the
    // request inputs are scrambled since they must not be read again.
    task automatic issue(input int loc, input int rot, input int typ,
                         input bit l, input bit r, input bit ro, input bit dr);
        sb.push_back(model(loc, rot, typ, l, r, ro, dr));
        @(negedge clka);
        curr_piece_location = LW'(loc);
        curr_piece_rotation = 2'(rot);
        curr_piece_type     = 2'(typ);
        left   = l;
        right  = r;
        rotate = ro;
        drop   = dr;
        start  = 1'b1;
        @(posedge clka);
        #1;
        start               = 1'b0;
        curr_piece_location = LW'($urandom_range(0, BW*BH-1));
        curr_piece_rotation = 2'($urandom_range(0, 3));
        curr_piece_type     = 2'($urandom_range(0, 3));
        left   = 1'($urandom_range(0, 1));
        right  = 1'($urandom_range(0, 1));
        rotate = 1'($urandom_range(0, 1));
        drop   = 1'($urandom_range(0, 1));
    endtask

    // Bounded wait for done; lat counts rising edges since the accept edge.
    task automatic wait_done(output int lat, output bit seen);
        lat  = 0;
        seen = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clka);
            #1;
            if (done === 1'b1) begin
                lat  = c;
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        left = 1'b0; right = 1'b1; rotate = 1'b0; drop = 1'b0;
        curr_piece_location = LW'(5);
        curr_piece_rotation = 2'd1;
        curr_piece_type     = 2'd1;
        #1;
        vectors++;
        if ({new_location, new_rotation, landed, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL reset_async: got loc=%0d rot=%0d landed=%b busy=%b done=%b, want all 0",
                     new_location, new_rotation, landed, busy, done);
        end
        repeat (2) @(posedge clka);
        #1;
        vectors++;
        if ({new_location, new_rotation, landed, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL reset_held: got loc=%0d rot=%0d landed=%b busy=%b done=%b, want all 0",
                     new_location, new_rotation, landed, busy, done);
        end
        @(negedge clka);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clka);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_right_move();
        exp_t e;
        int   lat;
        bit   seen;
        issue(5, 0, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_after_accept: got %b, want 1", busy);
        end
        wait_done(lat, seen);
        e = sb.pop_front();
        vectors++;
        if (!seen || lat != e.lat) begin
            miscompares++;
            $display("FAIL right_latency: got %0d (seen=%b), want %0d", lat, seen, e.lat);
        end
        vectors++;
        if ({new_location, new_rotation, landed} !== {e.loc, e.rot, e.landed}) begin
            miscompares++;
            $display("FAIL right_result: got loc=%0d rot=%0d landed=%b, want loc=%0d rot=%0d landed=%b",
                     new_location, new_rotation, landed, e.loc, e.rot, e.landed);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_in_done_cycle: got %b, want 0", busy);
        end
        repeat (2) @(posedge clka);
        #1;
        vectors++;
        if (done !== 1'b0 || {new_location, new_rotation, landed} !== {e.loc, e.rot, e.landed}) begin
            miscompares++;
            $display("FAIL done_pulse_hold: got done=%b loc=%0d rot=%0d landed=%b, want done=0 loc=%0d rot=%0d landed=%b",
                     done, new_location, new_rotation, landed, e.loc, e.rot, e.landed);
        end
    endtask

    // Table-driven directed cases: {loc, rot, type, left, right, rotate, drop}
    task automatic run_table(input string name, input int tbl[][7]);
        exp_t e;
        int   lat;
        bit   seen;
        foreach (tbl[i]) begin
            issue(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3] != 0, tbl[i][4] != 0,
                  tbl[i][5] != 0, tbl[i][6] != 0);
            wait_done(lat, seen);
            e = sb.pop_front();
            vectors++;
            if (!seen || lat != e.lat ||
                {new_location, new_rotation, landed} !== {e.loc, e.rot, e.landed}) begin
                miscompares++;
                $display("FAIL %s[%0d]: got loc=%0d rot=%0d landed=%b lat=%0d, want loc=%0d rot=%0d landed=%b lat=%0d",
                         name, i, new_location, new_rotation, landed, lat,
                         e.loc, e.rot, e.landed, e.lat);
            end
        end
    endtask

    task automatic test_left_edge();
        int tbl[][7];
        tbl = '{'{8, 0, 1, 1, 0, 0, 0}, '{9, 1, 1, 1, 1, 0, 0}, '{BW-1, 0, 2, 0, 1, 0, 0}};
        run_table("left_edge_priority", tbl);
    endtask

    task automatic test_rotate();
        int tbl[][7];
        tbl = '{'{1, 3, 1, 0, 0, 1, 0}, '{1, 2, 0, 0, 0, 1, 0}, '{2, 1, 3, 0, 0, 1, 0}};
        run_table("rotate_wrap_square", tbl);
    endtask

    task automatic test_landing();
        int tbl[][7];
        tbl = '{'{(BH-2)*BW, 0, 1, 0, 0, 0, 0}, '{BW*BH-3, 0, 1, 0, 0, 0, 0}};
        run_table("landing", tbl);
    endtask

    task automatic test_hard_drop();
        int tbl[][7];
        tbl = '{'{2, 0, 1, 0, 0, 0, 1}, '{(BH-2)*BW+1, 1, 2, 0, 0, 1, 1},
                '{(BH-1)*BW, 0, 1, 0, 1, 0, 1}, '{BW+1, 0, 1, 1, 0, 0, 1}};
        run_table("hard_drop", tbl);
    endtask

    task automatic test_random();
        int tbl[][7];
        tbl = new[20];
        foreach (tbl[i]) begin
            tbl[i][0] = $urandom_range(0, BW*BH-1);
            tbl[i][1] = $urandom_range(0, 3);
            tbl[i][2] = $urandom_range(0, 3);
            for (int k = 3; k < 7; k++) tbl[i][k] = $urandom_range(0, 1);
        end
        run_table("random", tbl);
    endtask

    task automatic test_busy_ignore();
        exp_t e;
        int   lat;
        bit   seen;
        int   extra;
        issue(BW+1, 1, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clka);
        start = 1'b1;
        left  = 1'b1;
        curr_piece_location = LW'(BW*BH-1);
        @(posedge clka);
        #1;
        start = 1'b0;
        wait_done(lat, seen);
        e = sb.pop_front();
        vectors++;
        if (!seen || lat != e.lat - 1 ||
            {new_location, new_rotation, landed} !== {e.loc, e.rot, e.landed}) begin
            miscompares++;
            $display("FAIL busy_ignore_result: got loc=%0d rot=%0d landed=%b lat=%0d, want loc=%0d rot=%0d landed=%b lat=%0d",
                     new_location, new_rotation, landed, lat, e.loc, e.rot, e.landed, e.lat - 1);
        end
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clka);
            #1;
            if (done === 1'b1) extra++;
        end
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("FAIL busy_ignore_extra_done: got %0d extra done pulses, want 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        issue(2*BW+2, 1, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(posedge clka);
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if ({new_location, new_rotation, landed, busy, done} !== '0) begin
            miscompares++;
            $display("FAIL reset_in_fall: got loc=%0d rot=%0d landed=%b busy=%b done=%b, want all 0",
                     new_location, new_rotation, landed, busy, done);
        end
        sb.delete();
        @(posedge clka);
        @(negedge clka);
        reset  = 1'b0;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clka);
            #1;
            if (done === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_discard: got %0d done pulses busy=%b, want 0 and 0", pulses, busy);
        end
    endtask

    task automatic test_back_to_back();
        int tbl[][7];
        tbl = '{'{5, 0, 1, 0, 1, 0, 0}, '{6, 2, 3, 0, 0, 1, 0}, '{0, 0, 1, 1, 0, 0, 0}};
        run_table("back_to_back", tbl);
    endtask

    initial begin
        start = 1'b0;
        left = 1'b0; right = 1'b0; rotate = 1'b0; drop = 1'b0;
        curr_piece_type = 2'd0;
        curr_piece_location = '0;
        curr_piece_rotation = 2'd0;
        reset = 1'b1;
        test_reset();
        test_right_move();
        test_left_edge();
        test_rotate();
        test_landing();
        test_hard_drop();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/move_piece_fsm.md
# move_piece_fsm

Parametrised successor to the single-step piece mover: accepts one user move (left/right/rotate) per request and then applies one row of gravity. Board dimensions are parameters. Handshake is start/done. Bottom-row landing is detected and reported. An optional hard-drop mode is included. Sits between the game-control FSM (GEN/MOVE/LAND/CLEAR/NEWBOARD) and the board-update logic; driven during the MOVE phase.

## Interface
- BOARD_W, 4, board columns (≥2, any integer)
- BOARD_H, 8, board rows (≥2)
- LOC_W, $clog2(BOARD_W*BOARD_H), location width (derived, do not override)
- clka  input  1  sole clock, rising-edge
- reset  input  1  asynchronous, active-high
- start  input  1  request pulse; sampled only in IDLE
- curr_piece_type  input  2  piece type; 2'b00 = square (rotation-invariant)
- curr_piece_location  input  LOC_W  row*BOARD_W + col, row 0 = top
- curr_piece_rotation  input  2  current rotation
- left, right, rotate  input  1  user controls, sampled with start
- drop  input  1  hard-drop request, sampled with start (used only with the macro)
- new_location  output  LOC_W  resulting location, registered
- new_rotation  output  2  resulting rotation, registered
- landed  output  1  piece is on the bottom row after the move; valid with done
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; outputs valid

## Operation
- States: IDLE → LATCH → SHIFT → FALL → DONE → IDLE.
- IDLE: when start=1, capture all inputs into internal regs; go to LATCH. Otherwise stay.
- LATCH: compute col = loc % BOARD_W and row = loc / BOARD_W from the captured location; go to SHIFT.
- SHIFT: apply exactly one action, priority left > right > rotate:
  - left: col==0 → hold; else loc−1.
  - right: col==BOARD_W−1 → hold; else loc+1.
  - rotate: type 2'b00 → hold; else rot+1 mod 4 (3 wraps to 0).
  - none asserted: no change.
- FALL: row==BOARD_H−1 → location unchanged, landed=1. Else loc+BOARD_W, and landed=1 iff the new row is BOARD_H−1.
- DONE: drive done=1 for one cycle; new_location/new_rotation/landed hold until the next done.
- start while busy is ignored and not queued. Control inputs are read only at the start-accept edge.
- Arithmetic: all location math is in LOC_W bits. Never produce a location ≥ BOARD_W*BOARD_H.
- Horizontal moves never change the row (no wrap across rows).

## Timing
- Reset values: new_location=0, new_rotation=0, landed=0, busy=0, done=0, state=IDLE.
- reset asserted mid-operation: immediate return to IDLE, all outputs at reset values, captured request discarded.
- start sampled high at edge N → busy high from N+1 → done high for the cycle after edge N+4 → busy low in that same cycle.
- Fixed latency: 4 cycles start-to-done (no hard drop). Earliest next accepted start is the done cycle+1.
- new_location, new_rotation and landed update on the edge that asserts done and are stable thereafter.

## Configuration
- MOVE_PIECE_HARD_DROP_EN defined: in FALL with captured drop=1, loop in FALL adding BOARD_W each cycle until row==BOARD_H−1. The loop takes (BOARD_H−1−row) cycles (minimum 1). landed=1. The SHIFT action is still applied first.
  - Latency becomes 3 + max(1, BOARD_H−1−row) cycles.
- Not defined: the drop input is ignored, FALL is always single-step, and latency is fixed at 4.

## Structure
- Shared package move_piece_pkg: state enum (IDLE, LATCH, SHIFT, FALL, DONE), piece-type constant PIECE_SQUARE=2'b00, and the game-phase constants GEN/MOVE/LAND/CLEAR/NEWBOARD shared with the control FSM.
- One sub-module piece_coords: combinational loc → (col,row) split, parametrised by BOARD_W/BOARD_H. The FSM and the row-compare logic stay in move_piece_fsm.

## Test plan
- Defaults: loc=5, rot=0, type=01, right=1, start pulse → after 4 cycles done=1, new_location=10, new_rotation=0, landed=0.
- Left at column 0: loc=8, left=1 → new_location=12 (no horizontal move); left=1 and right=1 together → left wins.
- Rotation wrap and square: rot=3, rotate=1, type=01 → new_rotation=0; type=00, rot=2 → new_rotation=2.
- Landing: loc=24, no action (row 6, BOARD_H=8) → new_location=28, landed=1; loc=29 → new_location=29, landed=1.
- Robustness: a second start while busy is ignored (exactly one done). reset asserted in FALL → all outputs 0 and no done pulse.
- With MOVE_PIECE_HARD_DROP_EN, BOARD_W=5, BOARD_H=6: loc=2, drop=1 → new_location=27, landed=1, done 8 cycles after start.
